// File: rtl/calib_if.sv
// calib_if: handshake bundle between calib_ctrl and its EEPROM, capture RAM and output consumer.
interface calib_if #(parameter int ADDR_W = 9, parameter int EEP_AW = 6);
  logic start;
  logic [1:0] ch;
  logic [ADDR_W-1:0] len;
  logic eep_rd;
  logic [EEP_AW-1:0] eep_addr;
  logic eep_rdy;
  logic [7:0] eep_data;
  logic smp_rd;
  logic [ADDR_W-1:0] smp_addr;
  logic [7:0] smp_data;
  logic out_vld;
  logic out_rdy;
  logic [7:0] out_data;
  logic [ADDR_W-1:0] out_idx;
  logic [7:0] off_q;
  logic [7:0] gain_q;
  logic busy;
  logic done;
  modport master (
    output start, ch, len, eep_rdy, eep_data, smp_data, out_rdy,
    input  eep_rd, eep_addr, smp_rd, smp_addr, out_vld, out_data, out_idx, off_q, gain_q, busy, done
  );
  modport slave (
    input  start, ch, len, eep_rdy, eep_data, smp_data, out_rdy,
    output eep_rd, eep_addr, smp_rd, smp_addr, out_vld, out_data, out_idx, off_q, gain_q, busy, done
  );
endinterface

// File: rtl/calib_ctrl.sv
// calib_ctrl: fetches per-channel offset/gain from EEPROM, streams capture RAM through the
// calibration arithmetic into a 2-entry output FIFO with valid/ready backpressure.
module calib_ctrl #(
  parameter int ADDR_W = 9,
  parameter int EEP_AW = 6
) (
  input logic clk,
  input logic rst,
  calib_if.slave bus
);
  typedef enum logic [2:0] {IDLE, EOFF, EGAIN, RUN, FIN} state_t;
  state_t st;
  logic [1:0] ch_q;
  logic [ADDR_W-1:0] len_q, rd_cnt, tx_cnt, infl_idx;
  logic infl, wp, rp, pop, last;
  logic [1:0] occ;
  logic [2:0] lvl;
  logic [ADDR_W+7:0] mem [2];
  logic signed [9:0] s10;
  logic [7:0] s8, res;
  logic [8:0] ph;
  assign pop = bus.out_vld & bus.out_rdy;
  // a slot freed by this cycle's transfer may be reused by a read issued in the same cycle
  assign lvl = {1'b0, occ} - {2'b0, pop} + {2'b0, infl};
  assign bus.smp_rd = st == RUN && rd_cnt != len_q && lvl < 3'd2;
  assign bus.smp_addr = rd_cnt;
  assign bus.out_vld = occ != 2'd0;
  assign {bus.out_idx, bus.out_data} = mem[rp];
  assign last = pop && tx_cnt == len_q - 1'b1;
  assign s10 = $signed({2'b00, bus.smp_data}) + $signed({{2{bus.off_q[7]}}, bus.off_q});
  assign s8 = s10[9] ? 8'h00 : s10[8] ? 8'hFF : s10[7:0];
  assign ph = 9'((16'(s8) * 16'(bus.gain_q)) >> 7);
  assign res = ph[8] ? 8'hFF : ph[7:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      occ <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      infl <= 1'b0;
      infl_idx <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      infl <= bus.smp_rd;
      infl_idx <= rd_cnt;
      if (infl) begin
        mem[wp] <= {infl_idx, res};
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      occ <= occ + {1'b0, infl} - {1'b0, pop};
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      ch_q <= '0;
      len_q <= '0;
      rd_cnt <= '0;
      tx_cnt <= '0;
      bus.eep_rd <= 1'b0;
      bus.eep_addr <= '0;
      bus.off_q <= '0;
      bus.gain_q <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.eep_rd <= 1'b0;
      bus.done <= 1'b0;
      if (bus.smp_rd) rd_cnt <= rd_cnt + 1'b1;
      if (pop) tx_cnt <= tx_cnt + 1'b1;
      case (st)
        IDLE: if (bus.start) begin
          ch_q <= bus.ch;
          len_q <= bus.len;
          rd_cnt <= '0;
          tx_cnt <= '0;
          bus.eep_rd <= 1'b1;
          bus.eep_addr <= EEP_AW'({bus.ch, 1'b0});
          bus.busy <= 1'b1;
          st <= EOFF;
        end
        EOFF: if (bus.eep_rdy) begin
          bus.off_q <= bus.eep_data;
          bus.eep_rd <= 1'b1;
          bus.eep_addr <= EEP_AW'({ch_q, 1'b1});
          st <= EGAIN;
        end
        EGAIN: if (bus.eep_rdy) begin
          bus.gain_q <= bus.eep_data;
          st <= len_q == '0 ? FIN : RUN;
          bus.done <= len_q == '0;
          bus.busy <= len_q != '0;
        end
        RUN: if (last) begin
          st <= FIN;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_calib_ctrl.sv
// tb_calib_ctrl: directed passes with hand-computed calibration results and cycle timing.
module tb_calib_ctrl;
  logic clk, rst;
  int checks = 0, errors = 0;
  logic [7:0] ram [512];
  calib_if bus ();
  calib_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.smp_rd) bus.smp_data <= ram[bus.smp_addr];
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] cal(input logic [7:0] raw, input logic [7:0] off, input logic [7:0] gain);
    int s, p;
    s = int'(raw) + int'($signed(off));
    s = s < 0 ? 0 : s > 255 ? 255 : s;
    p = s * int'(gain);
    if (p > 32767) p = 32767;
    return 8'(p >> 7);
  endfunction
  task automatic check_zero(input string tag);
    chk({tag, " ctl"}, {bus.eep_rd, bus.eep_addr, bus.smp_rd, bus.smp_addr, bus.out_vld}, 0);
    chk({tag, " dat"}, {bus.out_data, bus.out_idx, bus.off_q, bus.gain_q, bus.busy, bus.done}, 0);
  endtask
  task automatic eep_phase(input logic [1:0] c, input logic [7:0] off, input logic [7:0] gain, input int n);
    bus.start = 1'b1; bus.ch = c; bus.len = 9'(n);
    tick(); bus.start = 1'b0; #1;
    chk("eep_rd off", bus.eep_rd, 1);
    chk("eep_addr off", bus.eep_addr, {c, 1'b0});
    chk("busy", bus.busy, 1);
    tick(); #1;
    chk("eep_rd pulse", bus.eep_rd, 0);
    tick(); bus.eep_rdy = 1'b1; bus.eep_data = off;
    tick(); bus.eep_rdy = 1'b0; #1;
    chk("off_q", bus.off_q, off);
    chk("eep_rd gain", bus.eep_rd, 1);
    chk("eep_addr gain", bus.eep_addr, {c, 1'b1});
    tick(); bus.eep_rdy = 1'b1; bus.eep_data = gain;
    tick(); bus.eep_rdy = 1'b0;
  endtask
  task automatic run_pass(input logic [1:0] c, input logic [7:0] off, input logic [7:0] gain, input int n,
                          input logic [5:0] pat, input int plen, input int glitch);
    int issued = 0, got = 0, first = -1, last = 0, done_k = 0;
    logic stall = 1'b0;
    logic [7:0] pd = '0;
    logic [8:0] pi = '0;
    eep_phase(c, off, gain, n);
    for (int k = 1; k <= 200; k++) begin
      bus.out_rdy = pat[k % plen];
      bus.start = k == glitch; bus.ch = 2'd3; bus.len = 9'd2;
      bus.eep_rdy = k == glitch; bus.eep_data = 8'h55;
      #1;
      if (glitch > 0 && k == glitch + 1) chk("start ignored", bus.eep_rd, 0);
      chk("outstanding<=2", (issued - got) <= 2, 1);
      if (stall) begin
        chk("stall vld", bus.out_vld, 1);
        chk("stall data", bus.out_data, pd);
        chk("stall idx", bus.out_idx, pi);
      end
      if (bus.smp_rd) issued++;
      if (bus.out_vld && first < 0) first = k;
      if (bus.out_vld && bus.out_rdy) begin
        chk("out_idx", bus.out_idx, got);
        chk("out_data", bus.out_data, cal(ram[got], off, gain));
        got++;
        last = k;
      end
      if (bus.done) begin
        done_k = k;
        chk("busy at done", bus.busy, 0);
        break;
      end
      stall = bus.out_vld & ~bus.out_rdy;
      pd = bus.out_data;
      pi = bus.out_idx;
      tick();
    end
    bus.start = 1'b0; bus.eep_rdy = 1'b0;
    chk("done seen", done_k > 0, 1);
    chk("outputs", got, n);
    chk("reads", issued, n);
    chk("done after last", done_k, n == 0 ? 1 : last + 1);
    if (pat == 6'h3F && n > 0) begin
      chk("first vld m+3", first, 3);
      chk("done m+3+len", done_k, n + 3);
    end
    tick(); #1;
    chk("done pulse", bus.done, 0);
    chk("idle busy", bus.busy, 0);
    chk("off hold", bus.off_q, off);
    chk("gain hold", bus.gain_q, gain);
  endtask
  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.ch = '0; bus.len = '0;
    bus.eep_rdy = 1'b0; bus.eep_data = '0; bus.out_rdy = 1'b1;
    for (int i = 0; i < 512; i++) ram[i] = 8'(i * 3);
    tick(); tick(); #1;
    check_zero("reset");
    rst = 1'b0;
    tick();
    ram[0] = 8'h20;
    run_pass(2'd1, 8'h10, 8'h80, 1, 6'h3F, 6, 0);
    ram[0] = 8'hF0;
    run_pass(2'd0, 8'h7F, 8'h80, 1, 6'h3F, 6, 0);
    ram[0] = 8'h10;
    run_pass(2'd3, 8'h80, 8'h80, 1, 6'h3F, 6, 0);
    ram[0] = 8'hFF;
    run_pass(2'd0, 8'h00, 8'hFF, 1, 6'h3F, 6, 0);
    run_pass(2'd2, 8'h00, 8'h40, 1, 6'h3F, 6, 0);
    for (int i = 0; i < 8; i++) ram[i] = 8'(i * 3);
    run_pass(2'd2, 8'h00, 8'h80, 8, 6'b011001, 6, 0);
    run_pass(2'd1, 8'h05, 8'h90, 0, 6'h3F, 6, 0);
    run_pass(2'd1, 8'hF0, 8'hC0, 5, 6'b011001, 6, 4);
    begin
      logic seen = 1'b0;
      bus.out_rdy = 1'b0;
      eep_phase(2'd0, 8'h05, 8'h80, 4);
      for (int k = 0; k < 10; k++) begin
        #1;
        if (bus.out_vld) begin seen = 1'b1; break; end
        tick();
      end
      chk("vld before rst", seen, 1);
      rst = 1'b1; #1;
      check_zero("mid-run rst");
      tick(); tick();
      rst = 1'b0;
      tick();
    end
    ram[0] = 8'h20;
    run_pass(2'd1, 8'h10, 8'h80, 1, 6'h3F, 6, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
